// File: rtl/muldiv_sequencer_if.sv
// Handshake/result bundle between the EX/ID pipeline control and the HI/LO
// multiply/divide sequencer.
//   master (pipeline side): drives start, op, A, B, cancel, hilo_read;
//                           observes busy, stall, HI, LO, count.
//   slave  (sequencer)    : the reverse.
interface muldiv_sequencer_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        cancel;
    logic        hilo_read;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [3:0]  count;

    modport master (
        output start, op, A, B, cancel, hilo_read,
        input  busy, stall, HI, LO, count
    );

    modport slave (
        input  start, op, A, B, cancel, hilo_read,
        output busy, stall, HI, LO, count
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO unit sequencer for a MIPS-style pipeline.
// The 64-bit result of mult/multu (and div/divu when built in) is computed at
// the accept edge and parked in a pending register; the unit then stays busy
// for MUL_CYCLES/DIV_CYCLES edges and commits to HI/LO on the edge where the
// down-counter goes 1 -> 0. mthi/mtlo write HI/LO directly at the accept edge.
//
// Optional feature macro: MULDIV_DIVIDE_EN -- compiles in the div/divu
// datapath and DIV_CYCLES timing; without it op 010/011 are reserved.
//
// Ports:
//   clk    - single clock, rising edge
//   reset  - asynchronous active-high reset
//   bus    - muldiv_sequencer_if.slave:
//            start/op/A/B/cancel from EX, hilo_read from ID,
//            busy/stall/HI/LO/count back to the pipeline
// MUL_CYCLES and DIV_CYCLES must lie in 1..15 (count is 4 bits).
module muldiv_sequencer #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input logic               clk,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [3:0] MulCnt = 4'(MUL_CYCLES);
    localparam logic [3:0] DivCnt = 4'(DIV_CYCLES);
`ifdef MULDIV_DIVIDE_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [63:0] pending_q, pending_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic op_mul, op_div, op_md, op_mthi, op_mtlo, op_valid;
    logic accept, accept_md, commit, busy;

    // ------------------------------------------------------------------
    // Op decode and accept
    // ------------------------------------------------------------------
    always_comb begin
        op_mul   = (bus.op == 3'b000) || (bus.op == 3'b001);
        op_div   = DivEn && ((bus.op == 3'b010) || (bus.op == 3'b011));
        op_md    = op_mul || op_div;
        op_mthi  = (bus.op == 3'b100);
        op_mtlo  = (bus.op == 3'b101);
        op_valid = op_md || op_mthi || op_mtlo;
        accept    = bus.start && !bus.cancel && !busy && op_valid;
        accept_md = accept && op_md;
    end

    // ------------------------------------------------------------------
    // Result datapath
    // ------------------------------------------------------------------
    logic [63:0] mul_s, mul_u, md_result;

    always_comb begin
        mul_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
        mul_u = {32'd0, bus.A} * {32'd0, bus.B};
    end

`ifdef MULDIV_DIVIDE_EN
    logic [31:0] abs_a, abs_b, mag_q, mag_r, div_q, div_r;

    // Signed divide runs on magnitudes: quotient negated when signs differ,
    // remainder follows the dividend. 0x8000_0000 / -1 falls out as
    // quotient 0x8000_0000, remainder 0 through the 32-bit wrap.
    always_comb begin
        abs_a = bus.A[31] ? (32'd0 - bus.A) : bus.A;
        abs_b = bus.B[31] ? (32'd0 - bus.B) : bus.B;
        mag_q = '0;
        mag_r = '0;
        div_q = '0;
        div_r = '0;
        if (bus.B == 32'd0) begin
            div_q = 32'hFFFF_FFFF;
            div_r = bus.A;
        end else if (bus.op[0]) begin
            div_q = bus.A / bus.B;
            div_r = bus.A % bus.B;
        end else begin
            mag_q = abs_a / abs_b;
            mag_r = abs_a % abs_b;
            div_q = (bus.A[31] ^ bus.B[31]) ? (32'd0 - mag_q) : mag_q;
            div_r = bus.A[31] ? (32'd0 - mag_r) : mag_r;
        end
    end

    always_comb begin
        if (op_div) begin
            md_result = {div_r, div_q};
        end else begin
            md_result = bus.op[0] ? mul_u : mul_s;
        end
    end
`else
    always_comb begin
        md_result = bus.op[0] ? mul_u : mul_s;
    end
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept_md) state_d = StRun;
            StRun:   if (count_q <= 4'd1) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy   = (count_q != 4'd0);
        commit = (state_q == StRun) && (count_q == 4'd1);
        // Stall on a mul/div being issued this cycle as well as one in flight,
        // so the ID reader never sees stale HI/LO.
        bus.stall = bus.hilo_read && (busy || (bus.start && !bus.cancel && op_md));
        bus.busy  = busy;
        bus.count = count_q;
        bus.HI    = hi_q;
        bus.LO    = lo_q;
    end

    // ------------------------------------------------------------------
    // Counter, pending result and HI/LO
    // ------------------------------------------------------------------
    always_comb begin
        count_d   = count_q;
        pending_d = pending_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (accept_md) begin
            count_d   = op_div ? DivCnt : MulCnt;
            pending_d = md_result;
        end else if (busy) begin
            count_d = count_q - 4'd1;
        end
        // commit only happens while busy and accept only while idle: exclusive.
        if (commit) begin
            hi_d = pending_q[63:32];
            lo_d = pending_q[31:0];
        end else if (accept && op_mthi) begin
            hi_d = bus.A;
        end else if (accept && op_mtlo) begin
            lo_d = bus.A;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            pending_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            count_q   <= count_d;
            pending_q <= pending_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule
